// File: rtl/div_result_reconstructor.sv
// -----------------------------------------------------------------------------
// div_result_reconstructor
//
// Rebuilds a dividend from the output of the restoring divider:
//   dividend = quotient * divisor + remainder
// using a sequential shift-add multiplier (one partial product per cycle)
// followed by a single add of the remainder. It can serve as an in-system
// self-check stage placed after the divider.
//
// Handshake: operands are accepted with src_valid/src_ready. The result is
// presented with dest_valid/dest_ready and held until it is accepted. Only one
// operation is in flight at a time.
//
// Parameters
//   WIDTH        operand / result width (default 16)
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous reset, active low
//   src_valid    operands valid
//   src_ready    block idle and able to accept operands
//   quotient     multiplicand, unsigned
//   divisor      multiplier, unsigned
//   remainder    addend, unsigned, zero-extended
//   dest_valid   result valid, held until dest_ready
//   dest_ready   downstream accepts the result
//   dividend     low WIDTH bits of quotient*divisor + remainder
//   overflow     full result did not fit in WIDTH bits
//
// Build option
//   OVERFLOW_CHECK_EN  when defined the accumulator is 2*WIDTH bits wide and
//                      overflow reports a non-zero upper half. When undefined
//                      the accumulator is WIDTH bits (result wraps) and
//                      overflow is tied low.
//
// Latency: operands accepted at edge k give dest_valid after edge k+WIDTH+1.
// -----------------------------------------------------------------------------
module div_result_reconstructor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] remainder,
  output logic             dest_valid,
  input  logic             dest_ready,
  output logic [WIDTH-1:0] dividend,
  output logic             overflow
);

`ifdef OVERFLOW_CHECK_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] mcand;      // multiplicand, pre-shifted by the step count
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;    // accumulator plus remainder, used in ADD
  logic [WIDTH-1:0] mplier;     // multiplier, consumed LSB first
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dividend_q;
  logic [CNT_W-1:0] cnt;

  // Low WIDTH bits of the accumulator form the reconstructed dividend.
  function automatic logic [WIDTH-1:0] low_bits(input logic [ACC_W-1:0] a);
    return a[WIDTH-1:0];
  endfunction

  assign acc_sum = acc + ACC_W'(rem_q);

  // ---------------------------------------------------------------------------
  // Control: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (src_valid)        state_nxt = MUL;
      MUL:     if (cnt == CNT_LAST)  state_nxt = ADD;
      ADD:                           state_nxt = DONE;
      DONE:    if (dest_ready)       state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  assign src_ready  = (state == IDLE);
  assign dest_valid = (state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, shift-add steps, remainder add
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand      <= '0;
      mplier     <= '0;
      rem_q      <= '0;
      acc        <= '0;
      cnt        <= '0;
      dividend_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (src_valid) begin
            mcand  <= ACC_W'(quotient);
            mplier <= divisor;
            rem_q  <= remainder;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          // Shifting mcand left each step is equivalent to adding quotient<<cnt.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        ADD: begin
          acc        <= acc_sum;
          dividend_q <= low_bits(acc_sum);
        end
        default: begin
        end
      endcase
    end
  end

  assign dividend = dividend_q;

`ifdef OVERFLOW_CHECK_EN
  // Any set bit above WIDTH means the product plus remainder did not fit.
  function automatic logic ovf_flag(input logic [ACC_W-1:0] a);
    return |a[ACC_W-1:WIDTH];
  endfunction

  logic overflow_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (state == ADD) begin
      overflow_q <= ovf_flag(acc_sum);
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
